// File: rtl/cu_vertex_read_command_arbiter.sv
// ---------------------------------------------------------------------------
// cu_vertex_read_command_arbiter
//
// Purpose
//   Shares the single CU read-command path between the job-data requester and
//   the edge-data requester. A round-robin pointer resolves contention. The
//   number of issued-but-unanswered reads is limited by a credit counter.
//   Commands are registered before they reach cu_vertex_cache_reuse_control.
//   An enable/drain FSM lets the CU shut the path down cleanly: new grants
//   stop, and the block reports idle once every outstanding read is answered.
//
// Ports
//   clock              in   clock
//   rstn               in   synchronous reset, active-low
//   enabled_in         in   run enable from CU control
//   cmd_job_in         in   job-data read request (.valid + .payload)
//   cmd_job_ready      out  grant to the job requester this cycle
//   cmd_edge_in        in   edge-data read request (.valid + .payload)
//   cmd_edge_ready     out  grant to the edge requester this cycle
//   read_buffer_status in   downstream command buffer status (.alfull used)
//   read_response_in   in   read response; .valid returns one credit
//   read_command_out   out  arbitrated read command, registered
//   outstanding_count  out  current outstanding reads
//   idle_out           out  FSM in IDLE and no reads outstanding
//   credit_error_out   out  sticky: response seen with zero outstanding
// ---------------------------------------------------------------------------

package cu_vertex_read_command_arbiter_pkg;

  localparam int CMD_PAYLOAD_W  = 64;
  localparam int RESP_PAYLOAD_W = 64;

  typedef struct packed {
    logic                     valid;
    logic [CMD_PAYLOAD_W-1:0] payload;
  } CommandBufferLine;

  typedef struct packed {
    logic full;
    logic alfull;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic                      valid;
    logic [RESP_PAYLOAD_W-1:0] payload;
  } ResponseBufferLine;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Which requester wins the next contested cycle.
  typedef enum logic {
    RR_JOB  = 1'b0,
    RR_EDGE = 1'b1
  } rr_side_t;

endpackage

module cu_vertex_read_command_arbiter
  import cu_vertex_read_command_arbiter_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 16,
  localparam int OUTSTANDING_W   = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     enabled_in,
  input  CommandBufferLine         cmd_job_in,
  output logic                     cmd_job_ready,
  input  CommandBufferLine         cmd_edge_in,
  output logic                     cmd_edge_ready,
  input  BufferStatus              read_buffer_status,
  input  ResponseBufferLine        read_response_in,
  output CommandBufferLine         read_command_out,
  output logic [OUTSTANDING_W-1:0] outstanding_count,
  output logic                     idle_out,
  output logic                     credit_error_out
);

  localparam logic [OUTSTANDING_W-1:0] MAX_CNT = OUTSTANDING_W'(MAX_OUTSTANDING);
  localparam logic [OUTSTANDING_W-1:0] ONE_CNT = OUTSTANDING_W'(1);

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  arb_state_t               r_state;
  rr_side_t                 r_rr_ptr;
  logic [OUTSTANDING_W-1:0] r_outstanding;
  logic                     r_credit_error;
  CommandBufferLine         r_cmd_out;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic                     w_can_issue;
  logic                     w_job_req;
  logic                     w_edge_req;
  logic                     w_job_grant;
  logic                     w_edge_grant;
  logic                     w_issue;
  logic                     w_resp;
  logic                     w_underflow;
  logic [OUTSTANDING_W-1:0] w_outstanding_next;
  arb_state_t               w_state_next;
  rr_side_t                 w_rr_next;
  CommandBufferLine         w_granted_cmd;
  logic                     w_unused_ok;

  // Response payloads and the other buffer-status flags belong to other
  // consumers; only the credit pulse and alfull matter here.
  assign w_unused_ok = ^{read_response_in.payload,
                         read_buffer_status.full,
                         read_buffer_status.empty};

  assign w_job_req  = cmd_job_in.valid;
  assign w_edge_req = cmd_edge_in.valid;
  assign w_resp     = read_response_in.valid;

  // alfull only holds back new grants; responses keep returning credits.
  assign w_can_issue = (r_state == ST_RUN)
                     && !read_buffer_status.alfull
                     && (r_outstanding < MAX_CNT);

  // The rr pointer only matters when both sides ask at once. Grants are also
  // masked while rstn is low so nothing is handed out in a cycle whose issue
  // would be thrown away by the reset.
  assign w_job_grant  = rstn && w_can_issue && w_job_req
                      && (!w_edge_req || (r_rr_ptr == RR_JOB));
  assign w_edge_grant = rstn && w_can_issue && w_edge_req
                      && (!w_job_req || (r_rr_ptr == RR_EDGE));

  assign w_issue     = w_job_grant || w_edge_grant;
  assign w_underflow = w_resp && !w_issue && (r_outstanding == '0);

  assign cmd_job_ready  = w_job_grant;
  assign cmd_edge_ready = w_edge_grant;

  // -------------------------------------------------------------------------
  // Next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    w_outstanding_next = r_outstanding;
    w_rr_next          = r_rr_ptr;
    w_granted_cmd      = cmd_edge_in;

    if (w_job_grant) begin
      w_granted_cmd = cmd_job_in;
    end

    // A simultaneous issue and response cancel out. A stray response at zero
    // leaves the count at zero and is flagged through w_underflow instead.
    if (w_issue && !w_resp) begin
      w_outstanding_next = r_outstanding + ONE_CNT;
    end else if (!w_issue && w_resp && (r_outstanding != '0)) begin
      w_outstanding_next = r_outstanding - ONE_CNT;
    end

    // After a contested grant, the loser gets priority next time.
    if (w_job_grant && w_edge_req) begin
      w_rr_next = RR_EDGE;
    end else if (w_edge_grant && w_job_req) begin
      w_rr_next = RR_JOB;
    end
  end

  // -------------------------------------------------------------------------
  // Enable / drain FSM, next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enabled_in) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // The decision uses the count after this cycle's issue/response, so
        // a final grant taken while enable drops still goes through DRAIN.
        if (!enabled_in) begin
          w_state_next = (w_outstanding_next != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Re-enable wins over completion: if both happen together the
        // arbiter goes straight back to RUN.
        if (enabled_in) begin
          w_state_next = ST_RUN;
        end else if (w_outstanding_next == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments so that
    // every register samples pre-edge values regardless of statement order.
    if (!rstn) begin
      r_state           <= ST_IDLE;
      r_rr_ptr          <= RR_JOB;
      r_outstanding     <= '0;
      r_credit_error    <= 1'b0;
      r_cmd_out.valid   <= 1'b0;
      r_cmd_out.payload <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rr_ptr      <= w_rr_next;
      r_outstanding <= w_outstanding_next;

      if (w_underflow) begin
        r_credit_error <= 1'b1;
      end

      // The payload is only reloaded on an issue; between issues it keeps the
      // last command so downstream can see what was sent most recently.
      r_cmd_out.valid <= w_issue;
      if (w_issue) begin
        r_cmd_out.payload <= w_granted_cmd.payload;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign read_command_out  = r_cmd_out;
  assign outstanding_count = r_outstanding;
  assign credit_error_out  = r_credit_error;
  assign idle_out          = (r_state == ST_IDLE) && (r_outstanding == '0);

endmodule

// File: tb/tb_cu_vertex_read_command_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for cu_vertex_read_command_arbiter.
// A behavioural model is advanced once per cycle from the arbiter's rules:
// a credit count, a sticky error flag, a mode and whose turn it is when both
// sides ask. It is compared against every DUT output on each falling edge.
// Directed sequences pin the model down with hand-computed literal values.
// After them comes a long randomized run.
// ---------------------------------------------------------------------------

module tb_cu_vertex_read_command_arbiter;
  import cu_vertex_read_command_arbiter_pkg::*;

  localparam int TB_MAX = 4;
  localparam int CW     = $clog2(TB_MAX + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic en   = 1'b0;
  logic jv   = 1'b0;
  logic ev   = 1'b0;
  logic [63:0] jp = '0;
  logic [63:0] ep = '0;
  logic alfull = 1'b0;
  logic rv     = 1'b0;
  logic [63:0] rp = '0;

  CommandBufferLine  cmd_job, cmd_edge, cmd_out;
  BufferStatus       bstat;
  ResponseBufferLine resp;
  logic              job_ready, edge_ready, idle, cerr;
  logic [CW-1:0]     ocount;

  assign cmd_job  = {jv, jp};
  assign cmd_edge = {ev, ep};
  assign bstat    = {1'b0, alfull, 1'b0};
  assign resp     = {rv, rp};

  cu_vertex_read_command_arbiter #(.MAX_OUTSTANDING(TB_MAX)) dut (
    .clock              (clk),
    .rstn               (rstn),
    .enabled_in         (en),
    .cmd_job_in         (cmd_job),
    .cmd_job_ready      (job_ready),
    .cmd_edge_in        (cmd_edge),
    .cmd_edge_ready     (edge_ready),
    .read_buffer_status (bstat),
    .read_response_in   (resp),
    .read_command_out   (cmd_out),
    .outstanding_count  (ocount),
    .idle_out           (idle),
    .credit_error_out   (cerr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
  mode_t       m_mode     = M_IDLE;
  int          m_count    = 0;
  bit          m_err      = 1'b0;
  bit          m_edge_turn = 1'b0;
  bit          m_valid    = 1'b0;
  logic [63:0] m_payload  = '0;
  bit          m_live     = 1'b0;
  bit          j_granted  = 1'b0;
  bit          e_granted  = 1'b0;

  always @(negedge clk) begin : model_and_compare
    bit can, exp_j, exp_e, issue;
    exp_j = 1'b0;
    exp_e = 1'b0;
    if (rstn) begin
      can   = (m_mode == M_RUN) && !alfull && (m_count < TB_MAX);
      exp_j = can && jv && (!ev || !m_edge_turn);
      exp_e = can && ev && (!jv || m_edge_turn);
    end

    if (m_live) begin
      check("job_ready",   job_ready, exp_j);
      check("edge_ready",  edge_ready, exp_e);
      check("out_valid",   cmd_out.valid, m_valid);
      check("out_payload", cmd_out.payload, m_payload);
      check("outstanding", ocount, m_count);
      check("idle_out",    idle, (m_mode == M_IDLE) && (m_count == 0));
      check("credit_err",  cerr, m_err);
    end

    j_granted = jv && job_ready;
    e_granted = ev && edge_ready;

    if (!rstn) begin
      m_mode      = M_IDLE;
      m_count     = 0;
      m_err       = 1'b0;
      m_edge_turn = 1'b0;
      m_valid     = 1'b0;
      m_payload   = '0;
      m_live      = 1'b1;
    end else begin
      issue   = exp_j || exp_e;
      m_valid = issue;
      if (issue) m_payload = exp_j ? jp : ep;
      if (jv && ev && issue) m_edge_turn = exp_j;
      if (issue && !rv) m_count++;
      else if (rv && !issue) begin
        if (m_count == 0) m_err = 1'b1;
        else m_count--;
      end
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_RUN;
        M_RUN:   if (!en) m_mode = (m_count > 0) ? M_DRAIN : M_IDLE;
        M_DRAIN: if (en) m_mode = M_RUN;
                 else if (m_count == 0) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers: inputs change only 1 time unit after a rising edge
  // -------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; jv = 1'b0; ev = 1'b0; alfull = 1'b0; rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    // --- 1: job-only stream A,B,C ------------------------------------------
    do_reset();
    en = 1'b1; jv = 1'b1; jp = 64'hA;            // cycle 0, still IDLE
    mid(); check("t1_idle_no_grant", job_ready, 1'b0);
    check("t1_reset_idle", idle, 1'b1);
    next_cycle();                                 // cycle 1
    mid(); check("t1_grant_c1", job_ready, 1'b1);
    next_cycle(); jp = 64'hB;                     // cycle 2
    mid(); check("t1_out_a_valid", cmd_out.valid, 1'b1);
    check("t1_out_a", cmd_out.payload, 64'hA);
    next_cycle(); jp = 64'hC;                     // cycle 3
    mid(); check("t1_out_b", cmd_out.payload, 64'hB);
    next_cycle(); jv = 1'b0;                      // cycle 4
    mid(); check("t1_out_c", cmd_out.payload, 64'hC);
    check("t1_count3", ocount, 3);

    // --- 2: both requesters, alternating grants ----------------------------
    do_reset();
    en = 1'b1; jv = 1'b1; ev = 1'b1; jp = 64'h1111; ep = 64'h2222;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rv = (m_count > 0);
      mid();
      check("t2_job_turn",  job_ready,  (i % 2) == 0);
      check("t2_edge_turn", edge_ready, (i % 2) == 1);
      check("t2_one_hot",   job_ready & edge_ready, 1'b0);
    end
    next_cycle(); jv = 1'b0; ev = 1'b0; rv = 1'b0;

    // --- 3: credit limit ----------------------------------------------------
    do_reset();
    en = 1'b1; jv = 1'b1; jp = 64'h3333;
    repeat (8) next_cycle();
    mid(); check("t3_count_max", ocount, TB_MAX);
    check("t3_blocked", job_ready, 1'b0);
    next_cycle(); rv = 1'b1;
    mid(); check("t3_still_blocked", job_ready, 1'b0);
    next_cycle(); rv = 1'b0;
    mid(); check("t3_regrant", job_ready, 1'b1);
    check("t3_count_after_resp", ocount, TB_MAX - 1);
    next_cycle();
    mid(); check("t3_count_back", ocount, TB_MAX);
    check("t3_blocked_again", job_ready, 1'b0);
    next_cycle(); jv = 1'b0;

    // --- 4: alfull stall ----------------------------------------------------
    do_reset();
    en = 1'b1; alfull = 1'b1; jv = 1'b1; ev = 1'b1; jp = 64'h4444; ep = 64'h5555;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mid();
      check("t4_stall", {job_ready, edge_ready}, 2'b00);
    end
    next_cycle(); alfull = 1'b0;
    mid(); check("t4_release_job", job_ready, 1'b1);
    next_cycle(); jv = 1'b0; ev = 1'b0;

    // --- 5: drain and underflow --------------------------------------------
    do_reset();
    en = 1'b1; jv = 1'b1; jp = 64'h6666;          // cycle 0
    next_cycle();                                 // cycle 1: grant
    next_cycle(); jp = 64'h7777;                  // cycle 2: grant
    next_cycle(); jv = 1'b0; en = 1'b0;           // cycle 3: RUN -> DRAIN
    next_cycle(); jv = 1'b1; rv = 1'b1;           // cycle 4: DRAIN
    mid(); check("t5_drain_no_grant", job_ready, 1'b0);
    check("t5_drain_not_idle", idle, 1'b0);
    check("t5_drain_count", ocount, 2);
    next_cycle();                                 // cycle 5: 2nd response
    next_cycle(); rv = 1'b0;                      // cycle 6: IDLE
    mid(); check("t5_idle", idle, 1'b1);
    check("t5_no_err_yet", cerr, 1'b0);
    next_cycle(); rv = 1'b1; jv = 1'b0;           // cycle 7: extra response
    next_cycle(); rv = 1'b0;
    mid(); check("t5_credit_err", cerr, 1'b1);

    // --- 6: issue+response together, then mid-stream reset -----------------
    do_reset();
    en = 1'b1; jv = 1'b1; jp = 64'h8888;
    repeat (4) next_cycle();                      // cycle 4: count 3
    rv = 1'b1;
    mid(); check("t6_count3", ocount, 3);
    check("t6_grant_with_resp", job_ready, 1'b1);
    next_cycle(); rv = 1'b0; rstn = 1'b0;         // cycle 5
    mid(); check("t6_count_unchanged", ocount, 3);
    check("t6_no_grant_in_reset", job_ready, 1'b0);
    next_cycle(); rstn = 1'b1; jv = 1'b0;         // cycle 6
    mid(); check("t6_rst_valid", cmd_out.valid, 1'b0);
    check("t6_rst_payload", cmd_out.payload, 64'h0);
    check("t6_rst_count", ocount, 0);
    check("t6_rst_idle", idle, 1'b1);
    check("t6_rst_err", cerr, 1'b0);
    next_cycle(); rv = 1'b1;                      // late response
    next_cycle(); rv = 1'b0;
    mid(); check("t6_late_resp_err", cerr, 1'b1);

    // --- randomized run -----------------------------------------------------
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      if (!jv || j_granted) begin
        jv = ($urandom_range(0, 99) < 60);
        jp = {$urandom, $urandom};
      end
      if (!ev || e_granted) begin
        ev = ($urandom_range(0, 99) < 60);
        ep = {$urandom, $urandom};
      end
      en     = en ? ($urandom_range(0, 99) >= 3) : ($urandom_range(0, 99) < 30);
      alfull = ($urandom_range(0, 99) < 15);
      rv     = (m_count > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 199) == 0);
      rp     = {$urandom, $urandom};
      rstn   = ($urandom_range(0, 999) != 0);
    end
    next_cycle(); rstn = 1'b1; jv = 1'b0; ev = 1'b0; rv = 1'b0;
    mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
